// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-segment scanner with per-slot
// dead-time blanking, per-frame input latching, active-low outputs.
// Optional feature: define LZ_BLANK_EN for leading-zero suppression.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk_signal,
    input  logic        btn_reset,
    input  logic [15:0] data_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_enable,
    output logic        frame_start,
    output logic [3:0]  digit_select,
    output logic [7:0]  segment_data
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    localparam logic PH_BLANK = 1'b0;
    localparam logic PH_ON    = 1'b1;

    // cnt_q/idx_q/phase_q describe the slot position presented at the next edge
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          phase_q, phase_d;
    logic [15:0]   data_sh_q, data_sh_d;
    logic [3:0]    dp_sh_q, dp_sh_d;
    logic [3:0]    en_sh_q, en_sh_d;
    logic          fs_q, fs_d;
    logic [3:0]    dsel_q, dsel_d;
    logic [7:0]    seg_q, seg_d;

    logic          frame_edge;
    logic [3:0]    nib;
    logic [7:0]    seg_val;
    logic          lit;
    logic [3:0]    lz;

    function automatic logic [7:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hBF;
        endcase
    endfunction

    // Next-state: slot counter, digit index, phase, frame latch and registered outputs
    always_comb begin
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        data_sh_d = data_sh_q;
        dp_sh_d   = dp_sh_q;
        en_sh_d   = en_sh_q;
        fs_d      = 1'b0;
        dsel_d    = 4'hF;
        seg_d     = 8'hFF;

        frame_edge = (cnt_q == '0) && (idx_q == '0);

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (phase_q)
            PH_BLANK: if (cnt_q == BLANK_LAST) phase_d = PH_ON;
            default:  if (cnt_q == CNT_MAX)    phase_d = PH_BLANK;
        endcase

        // Position 0 of digit0 is always blank, so the old shadow never shows here
        if (frame_edge) begin
            data_sh_d = data_in;
            dp_sh_d   = dp_in;
            en_sh_d   = digit_enable;
            fs_d      = 1'b1;
        end

        nib     = data_sh_q[{idx_q, 2'b00} +: 4];
        seg_val = decode(nib);
        if (dp_sh_q[idx_q]) seg_val[7] = 1'b0;
        lit = en_sh_q[idx_q];

        lz    = 4'b0000;
`ifdef LZ_BLANK_EN
        lz[3] = (data_sh_q[15:12] == 4'd0);
        lz[2] = lz[3] && (data_sh_q[11:8] == 4'd0);
        lz[1] = lz[2] && (data_sh_q[7:4] == 4'd0);
        if (lz[idx_q]) begin
            if (dp_sh_q[idx_q]) seg_val = 8'h7F;
            else                lit     = 1'b0;
        end
`endif

        if ((phase_q == PH_ON) && lit) begin
            dsel_d = ~(4'b0001 << idx_q);
            seg_d  = seg_val;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_signal) begin
        if (btn_reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            phase_q   <= PH_BLANK;
            data_sh_q <= '0;
            dp_sh_q   <= '0;
            en_sh_q   <= '0;
            fs_q      <= 1'b0;
            dsel_q    <= '1;
            seg_q     <= '1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            data_sh_q <= data_sh_d;
            dp_sh_q   <= dp_sh_d;
            en_sh_q   <= en_sh_d;
            fs_q      <= fs_d;
            dsel_q    <= dsel_d;
            seg_q     <= seg_d;
        end
    end

    assign frame_start  = fs_q;
    assign digit_select = dsel_q;
    assign segment_data = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver (SCAN_DIV=8, BLANK_CYCLES=2).
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  en = '0;
    logic        fs;
    logic [3:0]  dsel;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(.SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk_signal   (clk),
        .btn_reset    (rst),
        .data_in      (data),
        .dp_in        (dp),
        .digit_enable (en),
        .frame_start  (fs),
        .digit_select (dsel),
        .segment_data (seg)
    );

    always #5 clk = ~clk;

    // Reference model: time since reset release, frame snapshot
    logic [7:0]  seg_tab [16];
    int          t = 0;
    bit          in_rst = 1'b1;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    logic [3:0]  m_en = '0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [7:0]  seg [4];
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
        end
    endtask

    task automatic model_expect(output logic e_fs, output logic [3:0] e_dsel, output logic [7:0] e_seg);
        int slot;
        int pos;
        logic [7:0] s;
        bit show;
        e_fs = 1'b0; e_dsel = 4'hF; e_seg = 8'hFF;
        if (!in_rst) begin
            pos  = t % 8;
            slot = (t / 8) % 4;
            e_fs = ((t % 32) == 0);
            if (pos >= 2) begin
                s    = seg_tab[(m_data >> (4 * slot)) & 16'hF];
                show = m_en[slot];
                if (m_dp[slot]) s[7] = 1'b0;
`ifdef LZ_BLANK_EN
                if (slot > 0 && (m_data >> (4 * slot)) == 0) begin
                    if (m_dp[slot]) s = 8'h7F;
                    else            show = 1'b0;
                end
`endif
                if (show) begin
                    e_dsel = ~(4'b0001 << slot);
                    e_seg  = s;
                end
            end
        end
    endtask

    task automatic tick();
        logic       e_fs;
        logic [3:0] e_dsel;
        logic [7:0] e_seg;
        @(posedge clk);
        if (rst) begin
            in_rst = 1'b1; t = 0; m_data = '0; m_dp = '0; m_en = '0;
        end else begin
            if (in_rst) t = 0; else t++;
            in_rst = 1'b0;
            if ((t % 32) == 0) begin
                m_data = data; m_dp = dp; m_en = en;
            end
        end
        @(negedge clk);
        model_expect(e_fs, e_dsel, e_seg);
        chk("model_frame_start", {7'd0, fs}, {7'd0, e_fs});
        chk("model_digit_select", {4'd0, dsel}, {4'd0, e_dsel});
        chk("model_segment_data", seg, e_seg);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    vec_t vecs [$];

    initial begin
        vec_t v;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

`ifdef LZ_BLANK_EN
        v = '{16'h0042, 4'h0, 4'hF, '{8'hA4, 8'h99, 8'hFF, 8'hFF}}; vecs.push_back(v);
        v = '{16'h0059, 4'h0, 4'hF, '{8'h90, 8'h92, 8'hFF, 8'hFF}}; vecs.push_back(v);
        v = '{16'h00A3, 4'h2, 4'hF, '{8'hB0, 8'h3F, 8'hFF, 8'hFF}}; vecs.push_back(v);
        v = '{16'h0007, 4'h0, 4'hF, '{8'hF8, 8'hFF, 8'hFF, 8'hFF}}; vecs.push_back(v);
        v = '{16'h0000, 4'h0, 4'hF, '{8'hC0, 8'hFF, 8'hFF, 8'hFF}}; vecs.push_back(v);
        v = '{16'h0105, 4'h0, 4'hF, '{8'h92, 8'hC0, 8'hF9, 8'hFF}}; vecs.push_back(v);
        v = '{16'h0000, 4'h4, 4'hF, '{8'hC0, 8'hFF, 8'h7F, 8'hFF}}; vecs.push_back(v);
`else
        v = '{16'h0042, 4'h0, 4'hF, '{8'hA4, 8'h99, 8'hC0, 8'hC0}}; vecs.push_back(v);
        v = '{16'h0059, 4'h0, 4'hF, '{8'h90, 8'h92, 8'hC0, 8'hC0}}; vecs.push_back(v);
        v = '{16'h00A3, 4'h2, 4'hF, '{8'hB0, 8'h3F, 8'hC0, 8'hC0}}; vecs.push_back(v);
        v = '{16'h0000, 4'h0, 4'hF, '{8'hC0, 8'hC0, 8'hC0, 8'hC0}}; vecs.push_back(v);
`endif
        v = '{16'h1234, 4'h5, 4'h5, '{8'h19, 8'hFF, 8'h24, 8'hFF}}; vecs.push_back(v);
        v = '{16'hBCDE, 4'h0, 4'hF, '{8'hBF, 8'hBF, 8'hBF, 8'hBF}}; vecs.push_back(v);
        v = '{16'h8760, 4'h8, 4'hF, '{8'hC0, 8'h82, 8'hF8, 8'h00}}; vecs.push_back(v);

        // Reset held 3 cycles
        do_reset(3);
        chk("reset_dsel", {4'd0, dsel}, 8'h0F);
        chk("reset_seg", seg, 8'hFF);
        chk("reset_fs", {7'd0, fs}, 8'h00);

        // Table-driven frames: one full frame per record, mid-ON sample per slot
        foreach (vecs[k]) begin
            data = vecs[k].data; dp = vecs[k].dp; en = vecs[k].en;
            do_reset(1);
            for (int c = 0; c < 32; c++) begin
                tick();
                if (c == 0) chk("tbl_fs_first", {7'd0, fs}, 8'h01);
                if ((c % 8) == 0) chk("tbl_blank_seg", seg, 8'hFF);
                if ((c % 8) == 4) begin
                    chk("tbl_seg", seg, vecs[k].seg[c / 8]);
                    chk("tbl_dsel", {4'd0, dsel},
                        (vecs[k].seg[c / 8] == 8'hFF) ? 8'h0F : {4'd0, ~(4'b0001 << (c / 8))});
                end
            end
            tick();
            chk("tbl_fs_period", {7'd0, fs}, 8'h01);
        end

        // Input change mid-frame is held off until the next frame
        data = 16'h0042; dp = '0; en = 4'hF;
        do_reset(1);
        for (int c = 0; c <= 10; c++) tick();
        data = 16'h0059;
        while (t < 12) tick();
        chk("tear_old_digit1", seg, 8'h99);
        while (t < 36) tick();
        chk("tear_new_digit0", seg, 8'h90);
        while (t < 44) tick();
        chk("tear_new_digit1", seg, 8'h92);

        // Reset during digit2 ON restarts the frame
        do_reset(1);
        while (t < 20) tick();
        chk("mid_dsel_digit2", {4'd0, dsel}, 8'h0B);
        rst = 1'b1;
        tick();
        chk("midrst_dsel", {4'd0, dsel}, 8'h0F);
        chk("midrst_seg", seg, 8'hFF);
        rst = 1'b0;
        tick();
        chk("midrst_fs", {7'd0, fs}, 8'h01);
        for (int c = 0; c < 4; c++) tick();
        chk("midrst_digit0", {4'd0, dsel}, 8'h0E);

        // Randomised stimulus against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                data = 16'($urandom) >> (4 * $urandom_range(0, 4));
                dp   = 4'($urandom);
                en   = 4'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
